// File: rtl/mac_kbd_pkg.sv
// Shared definitions for the Macintosh keyboard cable link.
// The package holds the link FSM state encoding, the default phase lengths
// in ce ticks (8 MHz tick rate), and the width of the phase counter.
package mac_kbd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_LO,
        TX_HI,
        REQ,
        RX_LO,
        RX_HI,
        RX_WAIT
    } kbdState_t;

    localparam int DEF_TX_LOW    = 1280;
    localparam int DEF_TX_HIGH   = 1360;
    localparam int DEF_RX_LOW    = 1440;
    localparam int DEF_RX_HIGH   = 1760;
    localparam int DEF_REQ_DELAY = 8;

    // Wide enough for the longest default phase (1760 ticks) with headroom.
    localparam int CNT_W = 12;

endpackage

// File: rtl/mac_kbd_phase_timer.sv
// Loadable down-counter that times one CLOCK phase of the keyboard link.
// Ports:
//   clk, reset      - system clock, asynchronous active-high reset
//   ce              - tick enable; the counter only moves on ce ticks
//   load, loadValue - reload the counter (takes priority over counting)
//   done            - counter has reached zero
// Loading N-1 on the tick that enters a phase makes done rise on the
// N-th tick spent in that phase.
module mac_kbd_phase_timer
    import mac_kbd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (ce) begin
            if (load) begin
                count <= loadValue;
            end else if (count != '0) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mac_kbd_link.sv
// Keyboard-end bit-level PHY for the Mac 128K/512K/Plus keyboard cable.
// The keyboard always drives CLOCK; the Mac asks to send a command byte by
// pulling DATA low. Bytes move MSB first.
// Ports:
//   clk, reset, ce         - system clock, async active-high reset, tick enable
//   kbd_clk_o, kbd_data_o  - open-drain CLOCK/DATA drives (1 = released)
//   kbd_data_i             - resolved DATA line level
//   tx_data/tx_valid/tx_ready - byte to send to the Mac (valid/ready handshake)
//   rx_data, rx_strobe     - last command byte from the Mac, one-tick update pulse
//   busy                   - link is in any state other than IDLE
module mac_kbd_link
    import mac_kbd_pkg::*;
#(
    parameter int TX_LOW    = DEF_TX_LOW,
    parameter int TX_HIGH   = DEF_TX_HIGH,
    parameter int RX_LOW    = DEF_RX_LOW,
    parameter int RX_HIGH   = DEF_RX_HIGH,
    parameter int REQ_DELAY = DEF_REQ_DELAY
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    output logic       kbd_clk_o,
    output logic       kbd_data_o,
    input  logic       kbd_data_i,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       busy
);

    localparam logic [CNT_W-1:0] TX_LOW_LD  = CNT_W'(TX_LOW - 1);
    localparam logic [CNT_W-1:0] TX_HIGH_LD = CNT_W'(TX_HIGH - 1);
    localparam logic [CNT_W-1:0] RX_LOW_LD  = CNT_W'(RX_LOW - 1);
    localparam logic [CNT_W-1:0] RX_HIGH_LD = CNT_W'(RX_HIGH - 1);
    localparam logic [CNT_W-1:0] REQ_LD     = CNT_W'(REQ_DELAY - 1);

    kbdState_t        state;
    kbdState_t        nextState;
    logic             syncMeta;
    logic             dsync;
    logic [7:0]       shiftReg;
    logic [2:0]       bitCnt;
    logic             timerLoad;
    logic [CNT_W-1:0] timerValue;
    logic             timerDone;
    logic             latchTx;
    logic             clearBits;
    logic             advanceBit;
    logic             shiftTx;
    logic             sampleRx;
    logic             finishRx;

    mac_kbd_phase_timer phaseTimer (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .load      (timerLoad),
        .loadValue (timerValue),
        .done      (timerDone)
    );

    // Two-flop synchronizer on DATA, advanced only on ce ticks so that the
    // request latency is counted in ticks regardless of the clk rate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncMeta <= 1'b1;
            dsync    <= 1'b1;
        end else if (ce) begin
            syncMeta <= kbd_data_i;
            dsync    <= syncMeta;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= nextState;
        end
    end

    // Next-state logic. Every phase change reloads the timer with the new
    // phase length minus one. A low DATA line in IDLE wins over tx_valid so
    // the Mac's command is never lost; the pending byte simply waits.
    always_comb begin
        nextState  = state;
        timerLoad  = 1'b0;
        timerValue = '0;
        latchTx    = 1'b0;
        clearBits  = 1'b0;
        advanceBit = 1'b0;
        shiftTx    = 1'b0;
        sampleRx   = 1'b0;
        finishRx   = 1'b0;
        case (state)
            IDLE: begin
                if (!dsync) begin
                    nextState  = REQ;
                    timerLoad  = 1'b1;
                    timerValue = REQ_LD;
                    clearBits  = 1'b1;
                end else if (tx_valid) begin
                    nextState  = TX_LO;
                    timerLoad  = 1'b1;
                    timerValue = TX_LOW_LD;
                    latchTx    = 1'b1;
                end
            end
            TX_LO: begin
                if (timerDone) begin
                    nextState  = TX_HI;
                    timerLoad  = 1'b1;
                    timerValue = TX_HIGH_LD;
                end
            end
            TX_HI: begin
                if (timerDone) begin
                    if (bitCnt == 3'd7) begin
                        nextState = IDLE;
                    end else begin
                        nextState  = TX_LO;
                        timerLoad  = 1'b1;
                        timerValue = TX_LOW_LD;
                        advanceBit = 1'b1;
                        shiftTx    = 1'b1;
                    end
                end
            end
            REQ: begin
                if (timerDone) begin
                    nextState  = RX_LO;
                    timerLoad  = 1'b1;
                    timerValue = RX_LOW_LD;
                end
            end
            RX_LO: begin
                if (timerDone) begin
                    nextState  = RX_HI;
                    timerLoad  = 1'b1;
                    timerValue = RX_HIGH_LD;
                    sampleRx   = 1'b1;
                end
            end
            RX_HI: begin
                if (timerDone) begin
                    if (bitCnt == 3'd7) begin
                        nextState = RX_WAIT;
                        finishRx  = 1'b1;
                    end else begin
                        nextState  = RX_LO;
                        timerLoad  = 1'b1;
                        timerValue = RX_LOW_LD;
                        advanceBit = 1'b1;
                    end
                end
            end
            RX_WAIT: begin
                // The Mac must release DATA before another request can start.
                if (dsync) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath: one shift register serves both directions since a transfer
    // is only ever going one way. The receive sample is the synchronized
    // line on the tick CLOCK rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shiftReg  <= '0;
            bitCnt    <= '0;
            rx_data   <= '0;
            rx_strobe <= 1'b0;
        end else if (ce) begin
            rx_strobe <= finishRx;
            if (latchTx || clearBits) begin
                bitCnt <= '0;
            end else if (advanceBit) begin
                bitCnt <= bitCnt + 3'd1;
            end
            if (latchTx) begin
                shiftReg <= tx_data;
            end else if (shiftTx) begin
                shiftReg <= {shiftReg[6:0], 1'b1};
            end else if (sampleRx) begin
                shiftReg <= {shiftReg[6:0], dsync};
            end
            if (finishRx) begin
                rx_data <= shiftReg;
            end
        end
    end

    // Line drives decode straight from state so an asynchronous reset
    // releases both lines without waiting for a clock edge.
    always_comb begin
        kbd_clk_o  = !((state == TX_LO) || (state == RX_LO));
        kbd_data_o = ((state == TX_LO) || (state == TX_HI)) ? shiftReg[7] : 1'b1;
    end

    assign busy = (state != IDLE);

    // Held low while reset is asserted even though the reset state is IDLE.
    assign tx_ready = (state == IDLE) && dsync && !reset;

endmodule
